// File: rtl/btn_rx.sv
// rtl/btn_rx.sv - push-button receiver: synchronizer, debounce FSM, press/release/long-press pulses, press counter
module btn_rx #(
    parameter int unsigned DEBOUNCE_CYC = 1000000,
    parameter int unsigned LONG_CYC     = 100000000,
    parameter bit          ACTIVE_LOW   = 1'b0
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       btn_raw,
    output logic       btn_level,
    output logic       press_p,
    output logic       release_p,
    output logic       long_p,
    output logic [7:0] press_cnt
);

    localparam logic [23:0] LP_DB_M1   = 24'(DEBOUNCE_CYC - 1);
    localparam logic [31:0] LP_LONG    = 32'(LONG_CYC);
    localparam logic [31:0] LP_LONG_M1 = 32'(LONG_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_DB,
        ST_HELD,
        ST_REL_DB
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_sync1;
    logic        r_sync2;
    logic        w_raw;
    logic        w_s;
    logic [23:0] r_db_cnt;
    logic [31:0] r_hold_cnt;
    logic        r_long_done;
    logic        r_btn_level;
    logic        r_press_p;
    logic        r_release_p;
    logic        r_long_p;
    logic [7:0]  r_press_cnt;

    logic        w_press;
    logic        w_release;
    logic        w_long;
    logic        w_db_clr;
    logic        w_db_inc;
    logic        w_hold_inc;

    assign w_raw = btn_raw ^ ACTIVE_LOW;
    assign w_s   = r_sync2;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= ST_IDLE;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_press    = 1'b0;
        w_release  = 1'b0;
        w_long     = 1'b0;
        w_db_clr   = 1'b0;
        w_db_inc   = 1'b0;
        w_hold_inc = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_s) begin
                    w_next   = ST_PRESS_DB;
                    w_db_clr = 1'b1;
                end
            end
            ST_PRESS_DB: begin
                if (!w_s) begin
                    w_next = ST_IDLE;
                end else if (r_db_cnt == LP_DB_M1) begin
                    w_next  = ST_HELD;
                    w_press = 1'b1;
                end else begin
                    w_db_inc = 1'b1;
                end
            end
            ST_HELD: begin
                // long_p only fires while staying in HELD, so it never lands in a REL_DB cycle
                if (!w_s) begin
                    w_next   = ST_REL_DB;
                    w_db_clr = 1'b1;
                end else begin
                    w_hold_inc = (r_hold_cnt != LP_LONG);
                    w_long     = (r_hold_cnt == LP_LONG_M1) && !r_long_done;
                end
            end
            ST_REL_DB: begin
                if (w_s) begin
                    w_next = ST_HELD;
                end else if (r_db_cnt == LP_DB_M1) begin
                    w_next    = ST_IDLE;
                    w_release = 1'b1;
                end else begin
                    w_db_inc = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_db_cnt    <= '0;
            r_hold_cnt  <= '0;
            r_long_done <= 1'b0;
            r_btn_level <= 1'b0;
            r_press_p   <= 1'b0;
            r_release_p <= 1'b0;
            r_long_p    <= 1'b0;
            r_press_cnt <= '0;
        end else begin
            r_press_p   <= w_press;
            r_release_p <= w_release;
            r_long_p    <= w_long;
            if (w_db_clr) begin
                r_db_cnt <= '0;
            end else if (w_db_inc) begin
                r_db_cnt <= r_db_cnt + 24'd1;
            end
            if (w_press) begin
                r_hold_cnt <= '0;
            end else if (w_hold_inc) begin
                r_hold_cnt <= r_hold_cnt + 32'd1;
            end
            if (w_press) begin
                r_long_done <= 1'b0;
            end else if (w_long) begin
                r_long_done <= 1'b1;
            end
            if (w_press) begin
                r_btn_level <= 1'b1;
                r_press_cnt <= r_press_cnt + 8'd1;
            end else if (w_release) begin
                r_btn_level <= 1'b0;
            end
        end
    end

    assign btn_level = r_btn_level;
    assign press_p   = r_press_p;
    assign release_p = r_release_p;
    assign long_p    = r_long_p;
    assign press_cnt = r_press_cnt;

endmodule

// File: tb/tb_btn_rx.sv
// tb/tb_btn_rx.sv - directed bench for btn_rx with DEBOUNCE_CYC=4, LONG_CYC=10
module tb_btn_rx;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       btn_raw = 1'b0;
    logic       btn_level;
    logic       press_p;
    logic       release_p;
    logic       long_p;
    logic [7:0] press_cnt;

    int n_pass  = 0;
    int n_total = 0;
    int n_press = 0;
    int n_rel   = 0;
    int n_long  = 0;

    logic rst_q      = 1'b1;
    logic prev_level = 1'b0;
    logic prev_pulse = 1'b0;

    btn_rx #(
        .DEBOUNCE_CYC(4),
        .LONG_CYC    (10),
        .ACTIVE_LOW  (1'b0)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .press_p  (press_p),
        .release_p(release_p),
        .long_p   (long_p),
        .press_cnt(press_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    always @(posedge sys_clk) rst_q <= sys_rst;

    // Pulse tally plus per-cycle invariants: one-hot pulses, no back-to-back pulses, level moves only with a pulse
    always @(negedge sys_clk) begin
        logic any_pulse;
        logic ok;
        any_pulse = press_p | release_p | long_p;
        ok = (32'(press_p) + 32'(release_p) + 32'(long_p) <= 32'd1)
             && !(any_pulse && prev_pulse)
             && (rst_q || (btn_level == prev_level) || press_p || release_p);
        chk("invariant", 32'(ok), 32'd1);
        n_press    += int'(press_p);
        n_rel      += int'(release_p);
        n_long     += int'(long_p);
        prev_level  = btn_level;
        prev_pulse  = any_pulse;
    end

    initial begin
        step(2);
        chk("rst_level", 32'(btn_level), 32'd0);
        chk("rst_press", 32'(press_p), 32'd0);
        chk("rst_release", 32'(release_p), 32'd0);
        chk("rst_long", 32'(long_p), 32'd0);
        chk("rst_cnt", 32'(press_cnt), 32'd0);
        sys_rst = 1'b0;
        step(2);

        btn_raw = 1'b1;
        step(6);
        chk("press_early", 32'(press_p), 32'd0);
        chk("level_early", 32'(btn_level), 32'd0);
        step(1);
        chk("press_pulse", 32'(press_p), 32'd1);
        chk("press_level", 32'(btn_level), 32'd1);
        chk("press_cnt1", 32'(press_cnt), 32'd1);
        step(1);
        chk("press_one_cycle", 32'(press_p), 32'd0);

        step(8);
        chk("long_early", 32'(long_p), 32'd0);
        step(1);
        chk("long_pulse", 32'(long_p), 32'd1);
        step(1);
        chk("long_one_cycle", 32'(long_p), 32'd0);

        btn_raw = 1'b0;
        step(2);
        btn_raw = 1'b1;
        step(20);
        chk("long_total", 32'(n_long), 32'd1);
        chk("no_rel_on_bounce", 32'(n_rel), 32'd0);
        chk("level_held", 32'(btn_level), 32'd1);

        btn_raw = 1'b0;
        step(6);
        chk("release_early", 32'(release_p), 32'd0);
        step(1);
        chk("release_pulse", 32'(release_p), 32'd1);
        chk("release_level", 32'(btn_level), 32'd0);
        step(1);
        chk("release_one_cycle", 32'(release_p), 32'd0);

        btn_raw = 1'b1; step(3);
        btn_raw = 1'b0; step(1);
        btn_raw = 1'b1; step(3);
        btn_raw = 1'b0; step(10);
        chk("bounce_no_press", 32'(n_press), 32'd1);
        chk("bounce_level", 32'(btn_level), 32'd0);
        chk("bounce_cnt", 32'(press_cnt), 32'd1);

        for (int i = 0; i < 254; i++) begin
            btn_raw = 1'b1; step(8);
            btn_raw = 1'b0; step(8);
        end
        chk("cnt_255", 32'(press_cnt), 32'd255);
        btn_raw = 1'b1; step(8);
        btn_raw = 1'b0; step(8);
        chk("cnt_wrap", 32'(press_cnt), 32'd0);
        chk("press_total", 32'(n_press), 32'd256);
        chk("release_total", 32'(n_rel), 32'd256);

        btn_raw = 1'b1;
        step(10);
        chk("held_before_rst", 32'(btn_level), 32'd1);
        sys_rst = 1'b1;
        step(1);
        sys_rst = 1'b0;
        chk("rst_held_level", 32'(btn_level), 32'd0);
        chk("rst_held_cnt", 32'(press_cnt), 32'd0);
        chk("rst_held_press", 32'(press_p), 32'd0);
        step(6);
        chk("repress_early", 32'(press_p), 32'd0);
        step(1);
        chk("repress_pulse", 32'(press_p), 32'd1);
        chk("repress_cnt", 32'(press_cnt), 32'd1);
        chk("no_rel_on_rst", 32'(n_rel), 32'd256);
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
